fp_result_normalizer: RTL and testbench
=======================================

Name: fp_result_normalizer

Overview:
Back end of the multi-precision PE datapath. Consumes the 66-bit two's-complement sum produced by the partial-product/accumulate adder tree, together with its unbiased exponent. Converts it to sign-magnitude, normalizes, rounds to nearest-even and packs an IEEE-style result for the selected precision. Two-stage valid/ready pipeline with backpressure.

Parameters:
EXP_W, 13, width of signed unbiased input exponent
SUM_W, 66, width of input two's-complement sum (fixed at 66; not intended to change)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_sum  input  66  two's-complement sum
in_exp  input  EXP_W  signed exponent; value = in_sum * 2^(in_exp-62)
in_mode  input  3  000 FP64, 001 FP32, 011 BF16, 100 FP16, others invalid
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  64  packed result; FP32 in [31:0], FP16/BF16 in [15:0], upper bits zero
out_flags  output  4  {invalid, overflow, underflow, inexact}
flags_clr  input  1  clears sticky flags (feature only)
sticky_flags  output  4  OR-accumulated out_flags (feature only)

Behaviour:
- Reset: clk and rst_n as stated; reset is asynchronous, active-low. out_valid=0, out_result=0, out_flags=0, sticky_flags=0, both pipeline-stage valids=0. in_ready=1 after release.
- Handshake: beat transfers on valid&ready. S2 advances when ~s2_valid|out_ready. S1 advances when ~s1_valid|s2_advance. in_ready = ~s1_valid|s1_advance (combinational; no ready-to-ready path outside the block).
- Latency: 2 cycles (accept at edge N, out_valid high after edge N+2) with out_ready=1. Full throughput 1 beat/cycle.
- While out_valid&~out_ready: out_result and out_flags hold stable. Beats are delivered in order, none dropped or duplicated.
- S1 (register): sign=in_sum[65]; mag=sign?-in_sum:in_sum as 66-bit unsigned (-2^65 -> 2^65, exact). lzc=leading-zero count of mag (0..66). Register exp and mode.
- S2 (register): E = exp + 3 - lzc (EXP_W+1 bits signed). Shift mag left by lzc. Fraction = bits below the leading one, truncated to 52/23/7/10 bits (FP64/FP32/BF16/FP16). Guard = next bit; sticky = OR of the remaining bits.
- Rounding: RNE. Round up if guard&(sticky|lsb). A rounding carry out of the fraction gives fraction=0 and E+1. inexact = guard|sticky.
- Biased exponent uses bias 1023/127/127/15 and max field 2047/255/255/31.
- If biased >= max: ±Inf, overflow=1, inexact=1.
- If biased <= 0: signed zero (flush; no subnormals), underflow=1, inexact=1.
- mag==0: +0, no flags.
- Invalid mode: result 0, invalid=1, other flags 0.
- Simultaneous in and out handshake while the pipeline is full: both occur in the same cycle, with no bubble.

Optional Feature:
STICKY_FLAGS_EN:
- Defined: sticky_flags |= out_flags on each output handshake. flags_clr clears it. If flags_clr coincides with a handshake, the clear wins and that handshake's flags are not accumulated.
- Undefined: sticky_flags tied to 0 and flags_clr ignored. Ports remain present.

Decomposition:
- Shared package fp_pe_pkg holds:
  - mode encodings MODE_FP64/FP32/BF16/FP16
  - per-mode constants: bias, exp max, fraction width
  - flag bit indices FLG_INVALID/OVF/UDF/INX
- One sub-module, lzc66: combinational 66-bit leading-zero counter, output 7 bits, mag==0 returns 66.

Test Plan:
- FP32 basic: in_sum=2^62, in_exp=0, mode 001 -> out_result=32'h3F800000, flags 0, out_valid 2 cycles after accept.
- FP64 negative: in_sum=-(3*2^61), in_exp=0, mode 000 -> 64'hBFF8000000000000, flags 0.
- FP16 rounding:
  - in_sum=2^62+2^51 (tie, lsb 0) -> 16'h3C00, inexact.
  - in_sum=2^62+2^52+2^51 -> 16'h3C02, inexact.
- FP16 range and special inputs:
  - in_exp=20 with in_sum=2^62 -> 16'h7C00, {0,1,0,1}.
  - in_exp=-20 -> 16'h0000, {0,0,1,1}.
  - in_sum=0 -> 0, flags 0.
  - mode 010 -> 0, invalid.
- Backpressure: 4 back-to-back beats, out_ready=0 for 5 cycles -> in_ready falls after 2 accepted; out_result stable; all 4 delivered in order once out_ready=1.
- Reset mid-operation: rst_n low with both stages valid -> out_valid=0 asynchronously; after release, no stale beat appears and in_ready=1.

Source files
------------

// File: rtl/fp_pe_pkg.sv
// fp_pe_pkg: precision mode encodings, per-precision IEEE constants and flag bit indices
package fp_pe_pkg;
   localparam logic [2:0] MODE_FP64 = 3'b000;
   localparam logic [2:0] MODE_FP32 = 3'b001;
   localparam logic [2:0] MODE_BF16 = 3'b011;
   localparam logic [2:0] MODE_FP16 = 3'b100;
   localparam int FLG_INVALID = 3;
   localparam int FLG_OVF     = 2;
   localparam int FLG_UDF     = 1;
   localparam int FLG_INX     = 0;
   function automatic logic mode_ok(input logic [2:0] m);
      return m == MODE_FP64 || m == MODE_FP32 || m == MODE_BF16 || m == MODE_FP16;
   endfunction
   function automatic logic [6:0] frac_w(input logic [2:0] m);
      return m == MODE_FP64 ? 7'd52 : m == MODE_FP32 ? 7'd23 : m == MODE_BF16 ? 7'd7 : 7'd10;
   endfunction
   function automatic logic [11:0] exp_bias(input logic [2:0] m);
      return m == MODE_FP64 ? 12'd1023 : m == MODE_FP16 ? 12'd15 : 12'd127;
   endfunction
   function automatic logic [11:0] exp_max(input logic [2:0] m);
      return m == MODE_FP64 ? 12'd2047 : m == MODE_FP16 ? 12'd31 : 12'd255;
   endfunction
endpackage

// File: rtl/fp_result_normalizer_lzc66.sv
// lzc66: leading-zero count of a 66-bit magnitude; an all-zero input returns 66
module lzc66 (
   input  logic [65:0] mag_i,
   output logic [6:0]  lzc_o
);
   // scan upward so the highest set bit has the final say
   always_comb begin
      lzc_o = 7'd66;
      for (int i = 0; i < 66; i++)
         if (mag_i[i]) lzc_o = 7'(65 - i);
   end
endmodule

// File: rtl/fp_result_normalizer.sv
// fp_result_normalizer: two-stage normalize / round-to-nearest-even / pack pipeline with valid-ready.
// Define STICKY_FLAGS_EN to enable OR-accumulated sticky_flags with flags_clr.
module fp_result_normalizer
   import fp_pe_pkg::*;
#(
   parameter int EXP_W = 13,
   parameter int SUM_W = 66
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] in_sum,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_result,
   output logic [3:0]       out_flags,
   input  logic             flags_clr,
   output logic [3:0]       sticky_flags
);
   localparam int EW = EXP_W + 3;
   logic s1_valid_q, s2_valid_q, s1_adv, s2_adv;
   logic s1_sign_q;
   logic [SUM_W-1:0] s1_mag_q, in_mag, sh;
   logic [6:0] s1_lzc_q, in_lzc, fw;
   logic [EXP_W-1:0] s1_exp_q;
   logic [2:0] s1_mode_q;
   logic [51:0] frac_t, frac_r, pfrac;
   logic [52:0] fsum;
   logic guard, sticky, up, carry, ovf, udf;
   logic signed [EW-1:0] e_rnd, biased, emax_s;
   logic [10:0] pexp;
   logic [63:0] pk, res_d, res_q;
   logic [3:0] flg_d, flg_q;
   assign s2_adv = ~s2_valid_q | out_ready;
   assign s1_adv = ~s1_valid_q | s2_adv;
   assign in_ready = ~s1_valid_q | s1_adv;
   assign in_mag = in_sum[SUM_W-1] ? -in_sum : in_sum;
   lzc66 u_lzc (.mag_i(in_mag), .lzc_o(in_lzc));
   // S1: capture sign-magnitude form, leading-zero count, exponent and mode
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_mag_q   <= '0;
         s1_lzc_q   <= '0;
         s1_exp_q   <= '0;
         s1_mode_q  <= '0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         s1_sign_q  <= in_sum[SUM_W-1];
         s1_mag_q   <= in_mag;
         s1_lzc_q   <= in_lzc;
         s1_exp_q   <= in_exp;
         s1_mode_q  <= in_mode;
      end
   // normalize, round to nearest even, range-check and pack the S1 contents
   always_comb begin
      fw     = frac_w(s1_mode_q);
      sh     = s1_mag_q << s1_lzc_q;
      frac_t = sh[64:13] >> (7'd52 - fw);
      guard  = sh[7'd64 - fw];
      sticky = |(sh & ((66'd1 << (7'd64 - fw)) - 66'd1));
      up     = guard & (sticky | frac_t[0]);
      fsum   = {1'b0, frac_t} + 53'(up);
      carry  = fsum[fw];
      frac_r = carry ? '0 : fsum[51:0];
      e_rnd  = EW'(signed'(s1_exp_q)) + EW'(3) - EW'(s1_lzc_q) + EW'(carry);
      biased = e_rnd + EW'(exp_bias(s1_mode_q));
      emax_s = EW'(exp_max(s1_mode_q));
      ovf    = biased >= emax_s;
      udf    = biased < EW'(1);
      pexp   = ovf ? 11'(exp_max(s1_mode_q)) : udf ? '0 : biased[10:0];
      pfrac  = (ovf | udf) ? '0 : frac_r;
      pk     = s1_mode_q == MODE_FP64 ? {s1_sign_q, pexp, pfrac}
             : s1_mode_q == MODE_FP32 ? {32'd0, s1_sign_q, pexp[7:0], pfrac[22:0]}
             : s1_mode_q == MODE_BF16 ? {48'd0, s1_sign_q, pexp[7:0], pfrac[6:0]}
             : {48'd0, s1_sign_q, pexp[4:0], pfrac[9:0]};
      res_d  = (!mode_ok(s1_mode_q) || s1_mag_q == '0) ? '0 : pk;
      flg_d  = '0;
      if (!mode_ok(s1_mode_q)) flg_d[FLG_INVALID] = 1'b1;
      else if (s1_mag_q != '0) begin
         flg_d[FLG_OVF] = ovf;
         flg_d[FLG_UDF] = udf;
         flg_d[FLG_INX] = guard | sticky | ovf | udf;
      end
   end
   // S2: registered result and flags, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         flg_q      <= '0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         res_q      <= res_d;
         flg_q      <= flg_d;
      end
   assign out_valid  = s2_valid_q;
   assign out_result = res_q;
   assign out_flags  = flg_q;
`ifdef STICKY_FLAGS_EN
   logic [3:0] sticky_q;
   // accumulate delivered flags; a clear overrides a coinciding handshake
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sticky_q <= '0;
      else if (flags_clr) sticky_q <= '0;
      else if (out_valid & out_ready) sticky_q <= sticky_q | flg_q;
   assign sticky_flags = sticky_q;
`else
   logic unused_flags_clr;
   assign unused_flags_clr = flags_clr;
   assign sticky_flags = '0;
`endif
endmodule

// File: tb/tb_fp_result_normalizer.sv
// tb_fp_result_normalizer: directed vector table plus backpressure and reset sequences
module tb_fp_result_normalizer;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, flags_clr = 1'b0;
   logic in_ready, out_valid;
   logic [65:0] in_sum = '0;
   logic [12:0] in_exp = '0;
   logic [2:0] in_mode = '0;
   logic [63:0] out_result;
   logic [3:0] out_flags, sticky_flags, model_sticky;
   logic [65:0] p62;
   int total = 0, bad = 0;
   typedef struct {
      logic [65:0] sum;
      logic [12:0] ex;
      logic [2:0]  mode;
      logic [63:0] res;
      logic [3:0]  flg;
   } vec_t;
   vec_t vt[20];
   logic [63:0] exp4[4];

   fp_result_normalizer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_exp(in_exp), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_flags(out_flags), .flags_clr(flags_clr), .sticky_flags(sticky_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic burst(input int stall);
      int idx = 0, oidx = 0;
      logic acc, del, hold = 1'b0;
      logic [63:0] held = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         out_ready = (c >= stall);
         in_valid = (idx < 4);
         in_sum = p62;
         in_exp = 13'(idx);
         in_mode = 3'b001;
         #1;
         if (hold) check("hold_result", out_result, held);
         if (stall == 0 && c < 4) check("no_bubble_ready", {63'd0, in_ready}, 64'd1);
         if (stall > 0 && c >= 2 && c < stall) check("stall_ready_low", {63'd0, in_ready}, 64'd0);
         if (stall > 0 && c == stall) check("accepted_before_release", 64'(idx), 64'd2);
         acc = in_valid & in_ready;
         del = out_valid & out_ready;
         if (del) begin
            if (oidx < 4) check("order", out_result, exp4[oidx]);
            else begin
               total++;
               bad++;
               $display("FAIL extra_beat: got %h expected none", out_result);
            end
            oidx++;
         end
         hold = out_valid & ~out_ready;
         held = out_result;
         @(posedge clk);
         if (acc) idx++;
      end
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("delivered_count", 64'(oidx), 64'd4);
   endtask

   initial begin
      p62 = 66'd1 << 62;
      vt[0]  = '{p62, 13'd0, 3'b001, 64'h3F800000, 4'b0000};
      vt[1]  = '{-(66'd3 << 61), 13'd0, 3'b000, 64'hBFF8000000000000, 4'b0000};
      vt[2]  = '{p62 + (66'd1 << 51), 13'd0, 3'b100, 64'h3C00, 4'b0001};
      vt[3]  = '{p62 + (66'd1 << 52) + (66'd1 << 51), 13'd0, 3'b100, 64'h3C02, 4'b0001};
      vt[4]  = '{p62, 13'd20, 3'b100, 64'h7C00, 4'b0101};
      vt[5]  = '{p62, 13'(-20), 3'b100, 64'h0, 4'b0011};
      vt[6]  = '{66'd0, 13'd0, 3'b100, 64'h0, 4'b0000};
      vt[7]  = '{p62, 13'd0, 3'b010, 64'h0, 4'b1000};
      vt[8]  = '{-p62, 13'd0, 3'b001, 64'hBF800000, 4'b0000};
      vt[9]  = '{p62, 13'd0, 3'b011, 64'h3F80, 4'b0000};
      vt[10] = '{66'd1 << 65, 13'd0, 3'b000, 64'hC020000000000000, 4'b0000};
      vt[11] = '{(66'd1 << 63) - 66'd1, 13'd0, 3'b001, 64'h40000000, 4'b0001};
      vt[12] = '{(66'd1 << 63) - 66'd1, 13'd15, 3'b100, 64'h7C00, 4'b0101};
      vt[13] = '{p62, 13'(-14), 3'b100, 64'h0400, 4'b0000};
      vt[14] = '{p62, 13'(-15), 3'b100, 64'h0, 4'b0011};
      vt[15] = '{-p62, 13'(-15), 3'b100, 64'h8000, 4'b0011};
      vt[16] = '{p62, 13'd0, 3'b111, 64'h0, 4'b1000};
      vt[17] = '{p62 | 66'd1, 13'd0, 3'b000, 64'h3FF0000000000000, 4'b0001};
      vt[18] = '{p62, 13'd1024, 3'b000, 64'h7FF0000000000000, 4'b0101};
      vt[19] = '{p62, 13'd1023, 3'b000, 64'h7FE0000000000000, 4'b0000};
      exp4 = '{64'h3F800000, 64'h40000000, 64'h40800000, 64'h41000000};
      model_sticky = '0;
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_result", out_result, 64'd0);
      check("rst_out_flags", {60'd0, out_flags}, 64'd0);
      check("rst_sticky", {60'd0, sticky_flags}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_sum = vt[k].sum;
         in_exp = vt[k].ex;
         in_mode = vt[k].mode;
         #1 check($sformatf("v%0d_in_ready", k), {63'd0, in_ready}, 64'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check($sformatf("v%0d_not_yet_valid", k), {63'd0, out_valid}, 64'd0);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_valid", k), {63'd0, out_valid}, 64'd1);
         check($sformatf("v%0d_result", k), out_result, vt[k].res);
         check($sformatf("v%0d_flags", k), {60'd0, out_flags}, {60'd0, vt[k].flg});
         model_sticky |= vt[k].flg;
         @(posedge clk);
         #1 check($sformatf("v%0d_single", k), {63'd0, out_valid}, 64'd0);
      end
`ifdef STICKY_FLAGS_EN
      check("sticky_accum", {60'd0, sticky_flags}, {60'd0, model_sticky});
`else
      check("sticky_tied", {60'd0, sticky_flags}, 64'd0);
`endif
      @(negedge clk);
      flags_clr = 1'b1;
      @(posedge clk);
      #1 flags_clr = 1'b0;
      check("sticky_cleared", {60'd0, sticky_flags}, 64'd0);
      burst(0);
      burst(5);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_sum = p62;
      in_exp = 13'd0;
      in_mode = 3'b001;
      @(posedge clk);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      check("pre_rst_ready", {63'd0, in_ready}, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", {63'd0, out_valid}, 64'd0);
      check("async_rst_result", out_result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1 check("no_stale_beat", {63'd0, out_valid}, 64'd0);
      end
      check("post_rst_ready", {63'd0, in_ready}, 64'd1);
      check("post_rst_sticky", {60'd0, sticky_flags}, 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
